mlp_stream_sequencer: RTL and testbench

//  Synthesizable DRAM->accelerator stream engine for the MLP Top core. Walks a layer of
//  out_tiles x in_tiles passes and streams packed ifmap, weight and bias words per pass

---
 rtl/mlp_stream_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_mlp_stream_sequencer.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mlp_stream_sequencer.sv
// DRAM->accelerator stream engine: walks out_tiles x in_tiles passes, streams
// ifmap/weight/bias words and routes ofmap beats to partial sums or results.
module mlp_stream_sequencer #(
    parameter int BUS_W    = 32,
    parameter int DATA_W   = 8,
    parameter int IN_TILE  = 64,
    parameter int OUT_TILE = 64,
    parameter int ADDR_W   = 16,
    parameter int TCNT_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [TCNT_W-1:0] cfg_in_tiles,
    input  logic [TCNT_W-1:0] cfg_out_tiles,
    input  logic [ADDR_W-1:0] cfg_if_base,
    input  logic [ADDR_W-1:0] cfg_w_base,
    input  logic [ADDR_W-1:0] cfg_b_base,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [BUS_W-1:0]  mem_rdata,
    output logic              top_ready,
    output logic              top_i_en,
    output logic [BUS_W-1:0]  top_data_in,
    input  logic              top_valid,
    input  logic [BUS_W-1:0]  top_ofmap,
    output logic              res_we,
    output logic [ADDR_W-1:0] res_addr,
    output logic [BUS_W-1:0]  res_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int PACK = BUS_W / DATA_W;
    localparam int IFW  = IN_TILE / PACK;
    localparam int KW   = (IFW > 1) ? $clog2(IFW) : 1;
    localparam int RW   = (OUT_TILE > 1) ? $clog2(OUT_TILE) : 1;
    localparam int BW   = RW + 1;
    localparam logic [ADDR_W-1:0] IFW_A = ADDR_W'(IFW);
    localparam logic [ADDR_W-1:0] OT_A  = ADDR_W'(OUT_TILE);
    localparam logic [KW-1:0]     K_LAST = KW'(IFW - 1);
    localparam logic [RW-1:0]     R_LAST = RW'(OUT_TILE - 1);
    localparam logic [BW-1:0]     B_FULL = BW'(OUT_TILE);

    typedef enum logic [3:0] {
        S_IDLE, S_WAIT, S_READY, S_IF, S_W, S_B, S_COLL, S_NEXT, S_FIN
    } state_t;

    state_t            state_q;
    logic [TCNT_W-1:0] nt_q, no_q, i_q, o_q;
    logic [ADDR_W-1:0] if_base_q, w_base_q, b_base_q;
    logic [KW-1:0]     k_q;
    logic [RW-1:0]     r_q, rsel_q;
    logic [BW-1:0]     bcnt_q;
    logic              req_q, mreq_q, psrc_req_q, ie_q, psrc_q;
    logic [ADDR_W-1:0] addr_q;
    logic              ready_q, busy_q, done_q, err_q;
    logic [BUS_W-1:0]  part_mem [OUT_TILE];
    logic [BUS_W-1:0]  part_q;

    logic [ADDR_W-1:0] i_a, o_a, k_a, r_a, nt_a;
    logic [ADDR_W-1:0] if_addr, w_addr, b_addr;
    logic              in_win, last_in, beat_acc, drained;

    always_comb begin
        i_a     = ADDR_W'(i_q);
        o_a     = ADDR_W'(o_q);
        k_a     = ADDR_W'(k_q);
        r_a     = ADDR_W'(r_q);
        nt_a    = ADDR_W'(nt_q);
        if_addr = if_base_q + i_a * IFW_A + k_a;
        w_addr  = w_base_q + (o_a * OT_A + r_a) * nt_a * IFW_A
                  + i_a * IFW_A + k_a;
        b_addr  = b_base_q + o_a * OT_A + r_a;
    end

    assign in_win   = state_q inside {S_READY, S_IF, S_W, S_B, S_COLL};
    assign last_in  = (i_q == nt_q - TCNT_W'(1));
    assign beat_acc = top_valid && in_win && (bcnt_q < B_FULL);
    assign drained  = !req_q && !ie_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            nt_q       <= '0;
            no_q       <= '0;
            i_q        <= '0;
            o_q        <= '0;
            if_base_q  <= '0;
            w_base_q   <= '0;
            b_base_q   <= '0;
            k_q        <= '0;
            r_q        <= '0;
            rsel_q     <= '0;
            bcnt_q     <= '0;
            req_q      <= 1'b0;
            mreq_q     <= 1'b0;
            psrc_req_q <= 1'b0;
            ie_q       <= 1'b0;
            psrc_q     <= 1'b0;
            addr_q     <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            req_q      <= 1'b0;
            mreq_q     <= 1'b0;
            psrc_req_q <= 1'b0;
            addr_q     <= '0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            ie_q       <= req_q;
            psrc_q     <= psrc_req_q;
            if (beat_acc) bcnt_q <= bcnt_q + BW'(1);
            if (top_valid && !beat_acc) err_q <= 1'b1;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        nt_q      <= (cfg_in_tiles == '0) ? TCNT_W'(1) : cfg_in_tiles;
                        no_q      <= (cfg_out_tiles == '0) ? TCNT_W'(1) : cfg_out_tiles;
                        if_base_q <= cfg_if_base;
                        w_base_q  <= cfg_w_base;
                        b_base_q  <= cfg_b_base;
                        i_q       <= '0;
                        o_q       <= '0;
                        err_q     <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!top_valid) begin
                        ready_q <= 1'b1;
                        bcnt_q  <= '0;
                        k_q     <= '0;
                        r_q     <= '0;
                        state_q <= S_READY;
                    end
                end
                S_READY: state_q <= S_IF;
                S_IF: begin
                    req_q  <= 1'b1;
                    mreq_q <= 1'b1;
                    addr_q <= if_addr;
                    if (k_q == K_LAST) begin
                        k_q     <= '0;
                        state_q <= S_W;
                    end else begin
                        k_q <= k_q + KW'(1);
                    end
                end
                S_W: begin
                    req_q  <= 1'b1;
                    mreq_q <= 1'b1;
                    addr_q <= w_addr;
                    if (k_q == K_LAST) begin
                        k_q <= '0;
                        if (r_q == R_LAST) begin
                            r_q     <= '0;
                            state_q <= S_B;
                        end else begin
                            r_q <= r_q + RW'(1);
                        end
                    end else begin
                        k_q <= k_q + KW'(1);
                    end
                end
                S_B: begin
                    // Later in-tile passes take their bias from the partial sums.
                    req_q  <= 1'b1;
                    rsel_q <= r_q;
                    if (i_q == '0) begin
                        mreq_q <= 1'b1;
                        addr_q <= b_addr;
                    end else begin
                        psrc_req_q <= 1'b1;
                    end
                    if (r_q == R_LAST) begin
                        r_q     <= '0;
                        state_q <= S_COLL;
                    end else begin
                        r_q <= r_q + RW'(1);
                    end
                end
                S_COLL: begin
                    if (drained && bcnt_q == B_FULL) state_q <= S_NEXT;
                end
                S_NEXT: begin
                    if (last_in) begin
                        i_q <= '0;
                        if (o_q == no_q - TCNT_W'(1)) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_FIN;
                        end else begin
                            o_q     <= o_q + TCNT_W'(1);
                            state_q <= S_WAIT;
                        end
                    end else begin
                        i_q     <= i_q + TCNT_W'(1);
                        state_q <= S_WAIT;
                    end
                end
                S_FIN: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Registered read keeps partial words aligned with the memory read latency.
    always_ff @(posedge clk) begin
        if (beat_acc && !last_in) part_mem[bcnt_q[RW-1:0]] <= top_ofmap;
        part_q <= part_mem[rsel_q];
    end

    assign mem_req     = mreq_q;
    assign mem_addr    = addr_q;
    assign top_ready   = ready_q;
    assign top_i_en    = ie_q;
    assign top_data_in = ie_q ? (psrc_q ? part_q : mem_rdata) : '0;
    assign res_we      = beat_acc && last_in;
    assign res_addr    = res_we ? (o_a * OT_A + ADDR_W'(bcnt_q)) : '0;
    assign res_wdata   = res_we ? top_ofmap : '0;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_mlp_stream_sequencer.sv
// Directed bench for mlp_stream_sequencer: ramp memory, scripted ofmap
// beats, stream/result capture compared against address formulas.
module tb_mlp_stream_sequencer;

    localparam int IFW = 16;
    localparam int OT  = 64;
    localparam int SPP = IFW + OT * IFW + OT;
    localparam int IFB = 'h0100;
    localparam int WB  = 'h1000;
    localparam int BB  = 'h0800;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  cfg_in_tiles = '0;
    logic [3:0]  cfg_out_tiles = '0;
    logic [15:0] cfg_if_base = '0;
    logic [15:0] cfg_w_base = '0;
    logic [15:0] cfg_b_base = '0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [31:0] mem_rdata = '0;
    logic        top_ready, top_i_en;
    logic [31:0] top_data_in;
    logic        top_valid = 1'b0;
    logic [31:0] top_ofmap = '0;
    logic        res_we;
    logic [15:0] res_addr;
    logic [31:0] res_wdata;
    logic        busy, done, err;

    mlp_stream_sequencer dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_in_tiles(cfg_in_tiles), .cfg_out_tiles(cfg_out_tiles),
        .cfg_if_base(cfg_if_base), .cfg_w_base(cfg_w_base),
        .cfg_b_base(cfg_b_base),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .top_ready(top_ready), .top_i_en(top_i_en),
        .top_data_in(top_data_in), .top_valid(top_valid),
        .top_ofmap(top_ofmap), .res_we(res_we), .res_addr(res_addr),
        .res_wdata(res_wdata), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] memf(input logic [15:0] a);
        return {a ^ 16'h5A00, ~a};
    endfunction

    function automatic logic [31:0] ofm(input int p, input int n);
        return 32'hC000_0000 | (32'(p) << 16) | 32'(n);
    endfunction

    always @(posedge clk)
        mem_rdata <= mem_req ? memf(mem_addr) : 32'hDEAD_BEEF;

    int pidx, sidx, ready_cnt, res_cnt, done_cnt, ie_cnt;
    int done_cyc, last_ie_cyc, last_beat_cyc;
    int slen [4];
    int res_pp [4];
    logic [31:0] strm [4][SPP];
    logic [31:0] resv [256];

    always @(negedge clk) begin
        if (top_ready) begin
            pidx = pidx + 1;
            sidx = 0;
            ready_cnt = ready_cnt + 1;
        end
        if (top_i_en) begin
            if (pidx >= 0 && pidx < 4 && sidx < SPP) strm[pidx][sidx] = top_data_in;
            sidx = sidx + 1;
            if (pidx >= 0 && pidx < 4) slen[pidx] = sidx;
            ie_cnt = ie_cnt + 1;
            last_ie_cyc = cyc;
        end
        if (res_we) begin
            res_cnt = res_cnt + 1;
            if (pidx >= 0 && pidx < 4) res_pp[pidx] = res_pp[pidx] + 1;
            if (res_addr < 256) resv[res_addr] = res_wdata;
        end
        if (top_valid) last_beat_cyc = cyc;
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    task automatic clear_mon();
        pidx = -1; sidx = 0; ready_cnt = 0; res_cnt = 0;
        done_cnt = 0; ie_cnt = 0; done_cyc = 0;
        last_ie_cyc = 0; last_beat_cyc = 0;
        for (int p = 0; p < 4; p++) begin
            slen[p] = 0;
            res_pp[p] = 0;
        end
        for (int a = 0; a < 256; a++) resv[a] = '0;
    endtask

    task automatic pulse_start(input int nt, input int no);
        @(posedge clk); #1;
        cfg_in_tiles  = 4'(nt);
        cfg_out_tiles = 4'(no);
        cfg_if_base   = 16'(IFB);
        cfg_w_base    = 16'(WB);
        cfg_b_base    = 16'(BB);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drive_pass(input int p, input int at, input int nb);
        int t = 0;
        while (!(pidx == p && sidx >= at)) begin
            @(posedge clk); #1;
            t++;
            if (t > 4000) begin
                checks++; errors++;
                $display("FAIL pass%0d_open: got no window, want top_ready", p);
                return;
            end
        end
        for (int n = 0; n < nb; n++) begin
            top_valid = 1'b1;
            top_ofmap = ofm(p, n);
            @(posedge clk); #1;
        end
        top_valid = 1'b0;
        top_ofmap = '0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (done_cnt == 0) begin
            @(posedge clk); #1;
            t++;
            if (t > 6000) begin
                checks++; errors++;
                $display("FAIL done_wait: got no done, want done pulse");
                return;
            end
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic run_layer(input int nt, input int no, input int at);
        clear_mon();
        pulse_start(nt, no);
        for (int p = 0; p < nt * no; p++) drive_pass(p, at, OT);
        wait_done();
    endtask

    function automatic logic [31:0] exp_w(input int o, input int i,
                                          input int nt, input int j, input int p);
        int t, r, k;
        if (j < IFW) return memf(16'(IFB + i * IFW + j));
        if (j < IFW + OT * IFW) begin
            t = j - IFW; r = t / IFW; k = t % IFW;
            return memf(16'(WB + (o * OT + r) * nt * IFW + i * IFW + k));
        end
        r = j - IFW - OT * IFW;
        if (i == 0) return memf(16'(BB + o * OT + r));
        return ofm(p - 1, r);
    endfunction

    task automatic check_streams(input int nt, input int no);
        for (int p = 0; p < nt * no; p++) begin
            int o, i, bad, first;
            o = p / nt; i = p % nt; bad = 0; first = 0;
            for (int j = 0; j < SPP; j++) begin
                if (strm[p][j] !== exp_w(o, i, nt, j, p)) begin
                    if (bad == 0) first = j;
                    bad++;
                end
            end
            checks++;
            if (slen[p] !== SPP) begin
                errors++;
                $display("FAIL stream_len p%0d: got %0d want %0d", p, slen[p], SPP);
            end
            checks++;
            if (bad !== 0) begin
                errors++;
                $display("FAIL stream p%0d: %0d bad, word %0d got %h want %h",
                         p, bad, first, strm[p][first], exp_w(o, i, nt, first, p));
            end
        end
    endtask

    task automatic check_results(input int nt, input int no);
        int bad = 0, first = 0;
        for (int o = 0; o < no; o++)
            for (int n = 0; n < OT; n++)
                if (resv[o * OT + n] !== ofm(o * nt + nt - 1, n)) begin
                    if (bad == 0) first = o * OT + n;
                    bad++;
                end
        checks++;
        if (res_cnt !== OT * no) begin
            errors++;
            $display("FAIL res_count: got %0d want %0d", res_cnt, OT * no);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL res_data: %0d bad, first index %0d got %h", bad, first, resv[first]);
        end
    endtask

    task automatic check_done_timing(input string nm);
        int m;
        m = (last_ie_cyc > last_beat_cyc) ? last_ie_cyc : last_beat_cyc;
        checks++;
        if (!(done_cyc > m && done_cyc <= m + 4)) begin
            errors++;
            $display("FAIL %s: got done cycle %0d want in (%0d,%0d]", nm, done_cyc, m, m + 4);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_status: got %b want 000", {busy, done, err});
        end
        checks++;
        if ({mem_req, mem_addr} !== 17'h0) begin
            errors++;
            $display("FAIL reset_mem: got %h want 0", {mem_req, mem_addr});
        end
        checks++;
        if ({top_ready, top_i_en, top_data_in, res_we} !== 35'h0) begin
            errors++;
            $display("FAIL reset_stream: got %h want 0", {top_ready, top_i_en, top_data_in, res_we});
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_single();
        run_layer(1, 1, 1060);
        checks++;
        if (ie_cnt !== 1104) begin
            errors++;
            $display("FAIL t1_beats: got %0d want 1104", ie_cnt);
        end
        checks++;
        if (strm[0][0] !== 32'h5B00_FEFF) begin
            errors++;
            $display("FAIL t1_word0: got %h want 5b00feff", strm[0][0]);
        end
        checks++;
        if (strm[0][1040] !== 32'h5200_F7FF) begin
            errors++;
            $display("FAIL t1_word1040: got %h want 5200f7ff", strm[0][1040]);
        end
        checks++;
        if (done_cnt !== 1 || ready_cnt !== 1) begin
            errors++;
            $display("FAIL t1_pulses: got done %0d ready %0d want 1 1", done_cnt, ready_cnt);
        end
        check_streams(1, 1);
        check_results(1, 1);
    endtask

    task automatic test_two_out();
        run_layer(1, 2, 1060);
        checks++;
        if (ready_cnt !== 2) begin
            errors++;
            $display("FAIL t2_ready: got %0d want 2", ready_cnt);
        end
        checks++;
        if (strm[1][16] !== 32'h4E00_EBFF) begin
            errors++;
            $display("FAIL t2_w0: got %h want 4e00ebff", strm[1][16]);
        end
        checks++;
        if (strm[1][1040] !== 32'h5240_F7BF) begin
            errors++;
            $display("FAIL t2_b0: got %h want 5240f7bf", strm[1][1040]);
        end
        check_streams(1, 2);
        check_results(1, 2);
    endtask

    task automatic test_two_in();
        run_layer(2, 1, 1060);
        checks++;
        if (strm[1][0] !== 32'h5B10_FEEF) begin
            errors++;
            $display("FAIL t3_if0: got %h want 5b10feef", strm[1][0]);
        end
        checks++;
        if (strm[1][16] !== 32'h4A10_EFEF) begin
            errors++;
            $display("FAIL t3_w0: got %h want 4a10efef", strm[1][16]);
        end
        checks++;
        if (strm[1][1040] !== 32'hC000_0000) begin
            errors++;
            $display("FAIL t3_b0: got %h want c0000000", strm[1][1040]);
        end
        checks++;
        if (res_pp[0] !== 0 || res_pp[1] !== 64) begin
            errors++;
            $display("FAIL t3_res_pass: got %0d/%0d want 0/64", res_pp[0], res_pp[1]);
        end
        check_streams(2, 1);
        check_results(2, 1);
    endtask

    task automatic test_err();
        clear_mon();
        @(posedge clk); #1;
        top_valid = 1'b1;
        top_ofmap = 32'h1234_5678;
        pulse_start(1, 1);
        repeat (8) @(posedge clk);
        @(negedge clk);
        checks++;
        if (ready_cnt !== 0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL t4_hold: got ready %0d busy %b want 0 1", ready_cnt, busy);
        end
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL t4_wait_err: got %b want 1", err);
        end
        @(posedge clk); #1;
        top_valid = 1'b0;
        drive_pass(0, 1060, 65);
        wait_done();
        checks++;
        if (res_cnt !== 64 || done_cnt !== 1) begin
            errors++;
            $display("FAIL t4_extra: got res %0d done %0d want 64 1", res_cnt, done_cnt);
        end
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL t4_extra_err: got %b want 1", err);
        end
        clear_mon();
        pulse_start(1, 1);
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL t4_clear: got %b want 0", err);
        end
        drive_pass(0, 1060, 64);
        wait_done();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL t4_clean_run: got %b want 0", err);
        end
        top_valid = 1'b1;
        @(posedge clk); #1;
        top_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (err !== 1'b1 || res_cnt !== 64) begin
            errors++;
            $display("FAIL t4_idle_beat: got err %b res %0d want 1 64", err, res_cnt);
        end
    endtask

    task automatic test_rst_mid();
        int t = 0;
        int ie0;
        clear_mon();
        pulse_start(1, 1);
        while (sidx < 100 && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        checks++;
        if (sidx < 100) begin
            errors++;
            $display("FAIL t5_reach_w: got %0d words want 100", sidx);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({mem_req, mem_addr, top_ready, top_i_en, top_data_in, res_we,
             res_addr, res_wdata, busy, done, err} !== '0) begin
            errors++;
            $display("FAIL t5_rst_outs: got req %b addr %h ie %b data %h busy %b want 0",
                     mem_req, mem_addr, top_i_en, top_data_in, busy);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        ie0 = ie_cnt;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++;
        if (ie_cnt !== ie0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL t5_idle: got ie %0d busy %b want %0d 0", ie_cnt, busy, ie0);
        end
        run_layer(1, 1, 1060);
        check_streams(1, 1);
        check_results(1, 1);
    endtask

    task automatic test_interleave();
        run_layer(1, 1, 1045);
        check_results(1, 1);
        check_streams(1, 1);
        check_done_timing("t6_late_beats");
        run_layer(1, 1, 0);
        check_results(1, 1);
        check_done_timing("t6_early_beats");
    endtask

    initial begin
        test_reset();
        test_single();
        test_two_out();
        test_two_in();
        test_err();
        test_rst_mid();
        test_interleave();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #800_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

endmodule
